pattern_pack_tx: RTL and testbench
==================================

// Module: pattern_pack_tx
// PURPOSE
// - Host-direction counterpart of the pack receiver in diff_freq_serial_out.
// - Takes one pack (output pattern, frequency pattern, control byte) and emits it byte-by-byte.
// - Drives the UART transmitter (i_tx_start / i_tx_data) and paces on its o_tx_done_tick.
// - Used for loopback/echo benches and for FPGA-to-FPGA pattern forwarding.
// PARAMETERS
// - DATA_BIT    32  width of each pattern; must be a multiple of 8, >= 8
// - GAP_CYCLES  0   idle clk cycles inserted after each byte's done tick before the next start (0..255)
// - PACK_NUM    derived localparam = (DATA_BIT/8)*2+1 (+1 with PACK_CHECKSUM_EN); not overridable
// PORTS
// - clk                 in   1         system clock
// - rst                 in   1         synchronous reset, active-high
// - i_start             in   1         one-cycle request to send a pack; sampled only in IDLE
// - i_output_pattern    in   DATA_BIT  output pattern, latched on accepted i_start
// - i_freq_pattern      in   DATA_BIT  frequency pattern, latched on accepted i_start
// - i_ctrl              in   8         control byte, latched on accepted i_start
// - i_tx_done_tick      in   1         UART tx byte-complete pulse
// - o_tx_start          out  1         one-cycle pulse to UART i_tx_start
// - o_tx_data           out  8         byte to UART i_tx_data; stable from o_tx_start until i_tx_done_tick
// - o_busy              out  1         high from the cycle after accept until o_done_tick
// - o_done_tick         out  1         one-cycle pulse: whole pack sent
// BEHAVIOUR
// - Reset: state IDLE; o_tx_start, o_tx_data, o_busy, o_done_tick, byte counter and shadow regs = 0.
// - Reset wins over every other input in the same cycle.
// - Reset mid-pack aborts the pack: no further o_tx_start and no o_done_tick.
// - Byte order:
//   - output pattern, LSB byte first;
//   - then frequency pattern, LSB byte first;
//   - then control byte (then checksum, if enabled).
// - FSM states:
//   - IDLE: on i_start, latch all inputs into shadow regs, clear byte counter -> LOAD.
//   - LOAD: drive o_tx_data = byte[cnt], pulse o_tx_start for exactly 1 cycle -> WAIT.
//   - WAIT: hold o_tx_data.
//     - On i_tx_done_tick with cnt == PACK_NUM-1: pulse o_done_tick, go -> IDLE.
//     - On any other i_tx_done_tick: cnt++, go -> GAP.
//   - GAP: count GAP_CYCLES clk cycles, then -> LOAD. With GAP_CYCLES = 0, GAP lasts exactly 1 cycle.
// - Latency:
//   - i_start accepted at edge N -> o_tx_start high in cycle N+1.
//   - Done tick at edge M -> next o_tx_start at cycle M+GAP_CYCLES+2 (GAP_CYCLES=0 -> M+2).
// - o_done_tick is registered and high in the first IDLE cycle.
// - i_start in that same cycle is accepted, allowing back-to-back packs.
// - i_start while o_busy is ignored; the shadow regs are not updated.
// - i_tx_done_tick in IDLE, LOAD or GAP is ignored and does not advance cnt.
// - Input patterns may change freely after accept; only the shadow copy is transmitted.
// - Byte counter width is $clog2(PACK_NUM); it never wraps past PACK_NUM-1.
// CONFIGURATION
// - Macro: PACK_CHECKSUM_EN.
// - Defined:
//   - one extra byte is appended after the control byte;
//   - value = XOR of all preceding pack bytes;
//   - PACK_NUM = (DATA_BIT/8)*2+2.
// - Undefined: no checksum byte; PACK_NUM = (DATA_BIT/8)*2+1. All other timing is identical.
// TESTING
// - Bench setup: DATA_BIT=32, GAP_CYCLES=0, UART model returning i_tx_done_tick 5 cycles after each o_tx_start.
// - T1 single pack: i_output_pattern=0x12345678, i_freq_pattern=0xA5A500FF, i_ctrl=0x81.
//   -> bytes 78 56 34 12 FF 00 A5 A5 81, each with exactly one o_tx_start pulse.
//   -> one o_done_tick, o_busy low afterwards.
// - T2 checksum: T1 stimulus with PACK_CHECKSUM_EN defined.
//   -> tenth byte 0x76, and o_done_tick only after that byte's done tick.
// - T3 ignore while busy: i_start with new values (0xFFFFFFFF) pulsed during byte 3.
//   -> transmitted stream is still T1's bytes; no second pack follows.
// - T4 back-to-back: i_start held in the o_done_tick cycle.
//   -> second pack's first o_tx_start exactly 1 cycle later; 18 bytes total.
// - T5 gap and stray ticks:
//   - GAP_CYCLES=4 -> 6 cycles from each done tick to the next o_tx_start.
//   - Extra i_tx_done_tick during GAP -> no byte is skipped.
// - T6 reset mid-pack: rst high for 1 cycle during byte 5.
//   -> all outputs 0 the next cycle; no further o_tx_start and no o_done_tick.
//   -> a fresh i_start then sends a full pack from byte 0.

Source files
------------

// File: rtl/pattern_pack_tx.sv
// pattern_pack_tx: sends {output pattern, freq pattern, ctrl} byte-by-byte to a UART transmitter.
// Defining PACK_CHECKSUM_EN appends an XOR checksum byte after the control byte.
module pattern_pack_tx #(
    parameter int DATA_BIT   = 32,
    parameter int GAP_CYCLES = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic [DATA_BIT-1:0] i_output_pattern,
    input  logic [DATA_BIT-1:0] i_freq_pattern,
    input  logic [7:0]          i_ctrl,
    input  logic                i_tx_done_tick,
    output logic                o_tx_start,
    output logic [7:0]          o_tx_data,
    output logic                o_busy,
    output logic                o_done_tick
);
`ifdef PACK_CHECKSUM_EN
    localparam int PACK_NUM = (DATA_BIT/8)*2+2;
`else
    localparam int PACK_NUM = (DATA_BIT/8)*2+1;
`endif
    localparam int CW = $clog2(PACK_NUM);
    localparam int PW = PACK_NUM*8;
    localparam logic [CW-1:0] LAST = CW'(PACK_NUM-1);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, GAP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    gap_q, gap_d;
    logic [PW-1:0] pack_q, pack_d, pack_in;
    logic          done_q, done_d;

`ifdef PACK_CHECKSUM_EN
    logic [7:0] chk;
    always_comb begin
        chk = i_ctrl;
        for (int b = 0; b < DATA_BIT/8; b++)
            chk = chk ^ i_output_pattern[b*8 +: 8] ^ i_freq_pattern[b*8 +: 8];
    end
    assign pack_in = {chk, i_ctrl, i_freq_pattern, i_output_pattern};
`else
    assign pack_in = {i_ctrl, i_freq_pattern, i_output_pattern};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        pack_d  = pack_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (i_start) begin
                pack_d  = pack_in;
                cnt_d   = '0;
                state_d = LOAD;
            end
            LOAD: state_d = WAIT;
            WAIT: if (i_tx_done_tick) begin
                if (cnt_q == LAST) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    gap_d   = '0;
                    state_d = GAP;
                end
            end
            // GAP spans GAP_CYCLES+1 cycles so a zero gap still costs one cycle
            GAP: if (gap_q == 8'(GAP_CYCLES)) state_d = LOAD;
                 else gap_d = gap_q + 1'b1;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gap_q   <= '0;
            pack_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            pack_q  <= pack_d;
            done_q  <= done_d;
        end
    end

    assign o_tx_start  = state_q == LOAD;
    assign o_tx_data   = pack_q[{cnt_q, 3'b000} +: 8];
    assign o_busy      = state_q != IDLE;
    assign o_done_tick = done_q;
endmodule

// File: tb/tb_pattern_pack_tx.sv
// tb_pattern_pack_tx: two DUTs (gap 0 and gap 4) driven by a UART model that ticks 5 cycles after each start.
// The gap-4 UART also injects a stray done tick two cycles after each genuine one.
module tb_pattern_pack_tx;
`ifdef PACK_CHECKSUM_EN
    localparam int PN = 10;
`else
    localparam int PN = 9;
`endif
    logic clk = 1'b0;
    logic rst;
    logic st [2];
    logic [31:0] op [2];
    logic [31:0] fp [2];
    logic [7:0] ct [2];
    logic tk [2];
    logic tg [2];
    logic txs [2];
    logic [7:0] txd [2];
    logic bsy [2];
    logic dn [2];

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    int cd [2] = '{0, 0};
    int sg [2] = '{0, 0};
    bit seen [2] = '{0, 0};
    bit prev_s [2] = '{0, 0};
    bit stray_en [2] = '{0, 1};
    int gapc [2] = '{0, 4};
    logic [7:0] cur [2];
    int acc [2];
    int st_cyc [2][$];
    logic [7:0] st_dat [2][$];
    int tk_cyc [2][$];
    int dn_q [2][$];
    logic [7:0] eq [$];

    typedef struct {
        logic [31:0] o;
        logic [31:0] f;
        logic [7:0]  c;
        logic [79:0] e;
    } vec_t;
    vec_t tbl [4];

    always #5 clk = ~clk;

    pattern_pack_tx #(.DATA_BIT(32), .GAP_CYCLES(0)) dut (
        .clk(clk), .rst(rst), .i_start(st[0]), .i_output_pattern(op[0]),
        .i_freq_pattern(fp[0]), .i_ctrl(ct[0]), .i_tx_done_tick(tk[0]),
        .o_tx_start(txs[0]), .o_tx_data(txd[0]), .o_busy(bsy[0]), .o_done_tick(dn[0])
    );

    pattern_pack_tx #(.DATA_BIT(32), .GAP_CYCLES(4)) dut_g (
        .clk(clk), .rst(rst), .i_start(st[1]), .i_output_pattern(op[1]),
        .i_freq_pattern(fp[1]), .i_ctrl(ct[1]), .i_tx_done_tick(tk[1]),
        .o_tx_start(txs[1]), .o_tx_data(txd[1]), .o_busy(bsy[1]), .o_done_tick(dn[1])
    );

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // UART model: tick in cycle S+5 for a start seen in cycle S
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < 2; k++) begin
            tk[k] <= (cd[k] == 1) || (stray_en[k] && sg[k] == 1);
            tg[k] <= (cd[k] == 1);
            cd[k] <= seen[k] ? 4 : (cd[k] > 0 ? cd[k] - 1 : 0);
            sg[k] <= (cd[k] == 1) ? 2 : (sg[k] > 0 ? sg[k] - 1 : 0);
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            seen[k] = txs[k];
            if (txs[k]) begin
                check("tx_start_one_cycle", 80'(prev_s[k]), 80'(0));
                st_cyc[k].push_back(cyc);
                st_dat[k].push_back(txd[k]);
                cur[k] = txd[k];
            end
            if (tg[k]) begin
                tk_cyc[k].push_back(cyc);
                if (bsy[k]) check("tx_data_stable", 80'(txd[k]), 80'(cur[k]));
            end
            if (dn[k]) dn_q[k].push_back(cyc);
            prev_s[k] = txs[k];
        end
    end

    function automatic void push_pack(input logic [31:0] o, input logic [31:0] f, input logic [7:0] c);
        logic [7:0] x = 8'h00;
        logic [7:0] b;
        for (int i = 0; i < 9; i++) begin
            b = i < 4 ? 8'(o >> (8*i)) : i < 8 ? 8'(f >> (8*(i-4))) : c;
            x = x ^ b;
            eq.push_back(b);
        end
`ifdef PACK_CHECKSUM_EN
        eq.push_back(x);
`endif
    endfunction

    task automatic launch(input int d, input logic [31:0] o, input logic [31:0] f,
                          input logic [7:0] c, input bit hold);
        st_cyc[d].delete(); st_dat[d].delete(); tk_cyc[d].delete(); dn_q[d].delete();
        @(posedge clk); #1;
        op[d] = o; fp[d] = f; ct[d] = c; st[d] = 1'b1; acc[d] = cyc;
        @(posedge clk); #1;
        if (!hold) st[d] = 1'b0;
        check("busy_after_accept", 80'(bsy[d]), 80'(1));
        op[d] = $urandom; fp[d] = $urandom; ct[d] = 8'($urandom);
    endtask

    task automatic wait_done(input int d, input int np);
        for (int i = 0; i < 1000 && dn_q[d].size() < np; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic check_pack(input int d, input int np, input string name);
        int n = eq.size();
        check({name, "_nbytes"}, 80'(st_dat[d].size()), 80'(n));
        check({name, "_ndone"}, 80'(dn_q[d].size()), 80'(np));
        for (int i = 0; i < n && i < st_dat[d].size(); i++)
            check({name, "_byte"}, 80'(st_dat[d][i]), 80'(eq[i]));
        if (st_cyc[d].size() > 0) check({name, "_first_lat"}, 80'(st_cyc[d][0]), 80'(acc[d] + 1));
        for (int i = 1; i < st_cyc[d].size() && i - 1 < tk_cyc[d].size(); i++)
            check({name, "_byte_lat"}, 80'(st_cyc[d][i] - tk_cyc[d][i-1]), 80'(2 + gapc[d]));
        for (int p = 0; p < np && p < dn_q[d].size() && (p+1)*PN - 1 < tk_cyc[d].size(); p++)
            check({name, "_done_lat"}, 80'(dn_q[d][p] - tk_cyc[d][(p+1)*PN - 1]), 80'(1));
        check({name, "_busy_after"}, 80'(bsy[d]), 80'(0));
    endtask

    initial begin
        int n;
        tbl[0] = '{32'h12345678, 32'hA5A500FF, 8'h81, {8'h76, 8'h81, 32'hA5A500FF, 32'h12345678}};
        tbl[1] = '{32'h00000000, 32'h00000000, 8'h00, {8'h00, 8'h00, 32'h00000000, 32'h00000000}};
        tbl[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 8'hFF, {8'hFF, 8'hFF, 32'hFFFFFFFF, 32'hFFFFFFFF}};
        tbl[3] = '{32'h01020304, 32'h10203040, 8'h5A, {8'h1E, 8'h5A, 32'h10203040, 32'h01020304}};
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            st[k] = 1'b0; op[k] = '0; fp[k] = '0; ct[k] = '0; cur[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check("reset_tx_start", 80'(txs[k]), 80'(0));
            check("reset_tx_data", 80'(txd[k]), 80'(0));
            check("reset_busy", 80'(bsy[k]), 80'(0));
            check("reset_done", 80'(dn[k]), 80'(0));
        end
        rst = 1'b0;

        // table vectors, both gap settings
        for (int d = 0; d < 2; d++)
            for (int t = 0; t < 4; t++) begin
                eq.delete();
                for (int i = 0; i < PN; i++) eq.push_back(tbl[t].e[8*i +: 8]);
                launch(d, tbl[t].o, tbl[t].f, tbl[t].c, 1'b0);
                wait_done(d, 1);
                check_pack(d, 1, d == 0 ? "table_gap0" : "table_gap4");
            end

        // random vectors against the byte model
        for (int r = 0; r < 16; r++) begin
            logic [31:0] o = $urandom;
            logic [31:0] f = $urandom;
            logic [7:0] c = 8'($urandom);
            int d = r % 4 == 3 ? 1 : 0;
            eq.delete();
            push_pack(o, f, c);
            launch(d, o, f, c, 1'b0);
            wait_done(d, 1);
            check_pack(d, 1, "random");
        end

        // new i_start while busy is ignored
        eq.delete();
        push_pack(32'h12345678, 32'hA5A500FF, 8'h81);
        launch(0, 32'h12345678, 32'hA5A500FF, 8'h81, 1'b0);
        for (int i = 0; i < 200 && st_cyc[0].size() < 4; i++) begin
            @(posedge clk); #1;
        end
        op[0] = 32'hFFFFFFFF; fp[0] = 32'hFFFFFFFF; ct[0] = 8'hFF; st[0] = 1'b1;
        @(posedge clk); #1;
        st[0] = 1'b0;
        wait_done(0, 1);
        check_pack(0, 1, "ignore_busy");
        repeat (30) @(posedge clk);
        #1;
        check("ignore_busy_no_second", 80'(st_cyc[0].size()), 80'(PN));

        // back-to-back: i_start held through the done-tick cycle
        eq.delete();
        push_pack(32'h12345678, 32'hA5A500FF, 8'h81);
        push_pack(32'hCAFEF00D, 32'h0BADBEEF, 8'h3C);
        launch(0, 32'h12345678, 32'hA5A500FF, 8'h81, 1'b1);
        op[0] = 32'hCAFEF00D; fp[0] = 32'h0BADBEEF; ct[0] = 8'h3C;
        wait_done(0, 1);
        st[0] = 1'b0;
        op[0] = $urandom;
        wait_done(0, 2);
        check_pack(0, 2, "back_to_back");
        if (st_cyc[0].size() > PN && dn_q[0].size() > 0)
            check("b2b_restart_lat", 80'(st_cyc[0][PN] - dn_q[0][0]), 80'(1));

        // reset mid-pack
        launch(0, 32'h12345678, 32'hA5A500FF, 8'h81, 1'b0);
        for (int i = 0; i < 200 && st_cyc[0].size() < 6; i++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_tx_start", 80'(txs[0]), 80'(0));
        check("midrst_tx_data", 80'(txd[0]), 80'(0));
        check("midrst_busy", 80'(bsy[0]), 80'(0));
        check("midrst_done", 80'(dn[0]), 80'(0));
        n = st_cyc[0].size();
        repeat (30) @(posedge clk);
        #1;
        check("midrst_no_more_start", 80'(st_cyc[0].size()), 80'(n));
        check("midrst_no_done", 80'(dn_q[0].size()), 80'(0));

        // reset beats a simultaneous i_start
        rst = 1'b1; st[0] = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; st[0] = 1'b0;
        check("rst_wins_busy", 80'(bsy[0]), 80'(0));
        check("rst_wins_start", 80'(txs[0]), 80'(0));
        repeat (10) @(posedge clk);

        eq.delete();
        push_pack(32'h12345678, 32'hA5A500FF, 8'h81);
        launch(0, 32'h12345678, 32'hA5A500FF, 8'h81, 1'b0);
        wait_done(0, 1);
        check_pack(0, 1, "after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks %0d failures", n_chk, n_fail);
        $fatal(1);
    end
endmodule
